// File: rtl/ram_line_reader_pkg.sv
// Shared types and constants for the ram_line_reader cache front-end.
package ram_line_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b000;

    // Number of low address bits that pick a word inside one line.
    function automatic int wsel_w(input int line_w, input int word_w);
        return $clog2(line_w / word_w);
    endfunction

    // Number of address bits that pick a cache line.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

endpackage

// File: rtl/ram_line_store.sv
// Direct-mapped line storage: per-beat data arrays, tag array and valid bits.
// One address port serves both lookup and fill, since the two never overlap.
module ram_line_store
    import ram_line_reader_pkg::*;
#(
    parameter int ADDR_W      = 27,
    parameter int WORD_W      = 16,
    parameter int UI_DATA_W   = 64,
    parameter int BURST_BEATS = 2,
    parameter int LINES       = 4,
    parameter int BC_W        = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    lk_addr_i,
    output logic                 lk_hit_o,
    output logic [WORD_W-1:0]    lk_word_o,
    input  logic                 wr_en_i,
    input  logic [BC_W-1:0]      wr_beat_i,
    input  logic [UI_DATA_W-1:0] wr_data_i,
    input  logic                 fill_done_i,
    input  logic                 flush_i
);

    localparam int LINE_W = UI_DATA_W * BURST_BEATS;
    localparam int WSEL_W = wsel_w(LINE_W, WORD_W);
    localparam int IDX_W  = idx_w(LINES);
    localparam int IA_W   = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W  = ADDR_W - WSEL_W - IDX_W;

    logic [IA_W-1:0]   idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic [LINE_W-1:0] line;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q [LINES];

    assign tag  = lk_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel = lk_addr_i[WSEL_W-1:0];

    generate
        if (IDX_W > 0) begin : g_idx
            assign idx = lk_addr_i[WSEL_W +: IA_W];
        end else begin : g_idx_single
            assign idx = '0;
        end
    endgenerate

    // One memory per beat so each fill beat is a plain full-width RAM write.
    generate
        for (genvar gi = 0; gi < BURST_BEATS; gi++) begin : g_beat
            logic [UI_DATA_W-1:0] mem_q [LINES];

            // Beat gi of the indexed line is written when that beat arrives.
            always_ff @(posedge clk) begin
                if (wr_en_i && (wr_beat_i == BC_W'(gi))) begin
                    mem_q[idx] <= wr_data_i;
                end
            end

            assign line[gi*UI_DATA_W +: UI_DATA_W] = mem_q[idx];
        end
    endgenerate

    // Tag is captured when a fill completes.
    always_ff @(posedge clk) begin
        if (fill_done_i) begin
            tag_q[idx] <= tag;
        end
    end

    // Flush wipes every line, but a fill finishing in the same cycle survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= '0;
            end
            if (fill_done_i) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    assign lk_hit_o  = valid_q[idx] && (tag_q[idx] == tag);
    assign lk_word_o = line[int'(wsel)*WORD_W +: WORD_W];

endmodule

// File: rtl/ram_line_reader.sv
// Cached single-word read front-end for the MIG UI.
// Optional hit/miss counters are enabled with macro RAM_LINE_READER_STATS_EN.
module ram_line_reader
    import ram_line_reader_pkg::*;
#(
    parameter int ADDR_W      = 27,
    parameter int WORD_W      = 16,
    parameter int UI_DATA_W   = 64,
    parameter int BURST_BEATS = 2,
    parameter int LINES       = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    output logic                 rsp_valid,
    output logic [WORD_W-1:0]    rsp_data,
    input  logic                 flush,
    output logic [ADDR_W-1:0]    ram_address,
    output logic [2:0]           ram_cmd,
    output logic                 ram_en,
    input  logic                 ram_rdy,
    input  logic                 ram_rd_valid,
    input  logic                 ram_rd_data_end,
    input  logic [UI_DATA_W-1:0] ram_rd_data,
    output logic                 burst_err
`ifdef RAM_LINE_READER_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    localparam int LINE_W = UI_DATA_W * BURST_BEATS;
    localparam int WSEL_W = wsel_w(LINE_W, WORD_W);
    localparam int WPB    = UI_DATA_W / WORD_W;
    localparam int BC_W   = $clog2(BURST_BEATS + 1);
    localparam logic [BC_W-1:0]   NBEATS     = BC_W'(BURST_BEATS);
    localparam logic [BC_W-1:0]   LAST_BEAT  = BC_W'(BURST_BEATS - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'((1 << WSEL_W) - 1));

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BC_W-1:0]     beat_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [WORD_W-1:0]   rsp_data_q;
    logic                ram_en_q;
    logic [2:0]          ram_cmd_q;
    logic [ADDR_W-1:0]   ram_address_q;
    logic                burst_err_q;

    logic [ADDR_W-1:0]   lk_addr;
    logic                lk_hit;
    logic [WORD_W-1:0]   lk_word;
    logic                accept;
    logic                hit;
    logic                beat_wr;
    logic                fill_done;
    logic [WORD_W-1:0]   fill_word;

    // Lookups use the live request address only while waiting for a request.
    assign lk_addr   = (state_q == IDLE) ? req_addr : addr_q;
    assign accept    = (state_q == IDLE) && req_valid && req_ready_q;
    assign hit       = lk_hit && !flush;
    assign beat_wr   = (state_q == DATA) && ram_rd_valid && (beat_q < NBEATS);
    assign fill_done = (state_q == DATA) && ram_rd_valid && ram_rd_data_end;

    // The requested word may sit in the beat being written right now, so bypass it.
    always_comb begin
        fill_word = lk_word;
        if (beat_wr && ((int'(addr_q[WSEL_W-1:0]) / WPB) == int'(beat_q))) begin
            fill_word = ram_rd_data[(int'(addr_q[WSEL_W-1:0]) % WPB)*WORD_W +: WORD_W];
        end
    end

    ram_line_store #(
        .ADDR_W      (ADDR_W),
        .WORD_W      (WORD_W),
        .UI_DATA_W   (UI_DATA_W),
        .BURST_BEATS (BURST_BEATS),
        .LINES       (LINES),
        .BC_W        (BC_W)
    ) u_store (
        .clk         (clk),
        .reset_n     (reset_n),
        .lk_addr_i   (lk_addr),
        .lk_hit_o    (lk_hit),
        .lk_word_o   (lk_word),
        .wr_en_i     (beat_wr),
        .wr_beat_i   (beat_q),
        .wr_data_i   (ram_rd_data),
        .fill_done_i (fill_done),
        .flush_i     (flush)
    );

    // Request / command / fill / response sequencing with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            beat_q        <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            ram_en_q      <= 1'b0;
            ram_cmd_q     <= CMD_WRITE;
            ram_address_q <= '0;
            burst_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        addr_q      <= req_addr;
                        req_ready_q <= 1'b0;
                        if (hit) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= lk_word;
                        end else begin
                            state_q       <= CMD;
                            ram_en_q      <= 1'b1;
                            ram_cmd_q     <= CMD_READ;
                            ram_address_q <= req_addr & ALIGN_MASK;
                        end
                    end
                end
                CMD: begin
                    if (ram_rdy) begin
                        state_q   <= DATA;
                        ram_en_q  <= 1'b0;
                        ram_cmd_q <= CMD_WRITE;
                        beat_q    <= '0;
                    end
                end
                DATA: begin
                    if (ram_rd_valid) begin
                        if (beat_q < NBEATS) begin
                            beat_q <= beat_q + 1'b1;
                        end
                        if (ram_rd_data_end) begin
                            if (beat_q != LAST_BEAT) begin
                                burst_err_q <= 1'b1;
                            end
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= fill_word;
                        end else if (beat_q >= NBEATS) begin
                            burst_err_q <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef RAM_LINE_READER_STATS_EN
    // Saturating lookup-outcome counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) begin
                if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
                if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign ram_en      = ram_en_q;
    assign ram_cmd     = ram_cmd_q;
    assign ram_address = ram_address_q;
    assign burst_err   = burst_err_q;

endmodule
